// File: rtl/asymmetric_fifo_ctrl.sv
// Wide-in / narrow-out FIFO control around an asymmetric RAM.
// ASYM_FIFO_OVERFLOW_FLAG_EN adds a sticky overflow output.
module asymmetric_fifo_ctrl #(
  parameter int WIDTH_IN     = 64,
  parameter int WIDTH_OUT    = 8,
  parameter int DEPTH_IN     = 32,
  parameter int ADDR_A_WIDTH = $clog2(DEPTH_IN),
  parameter int ADDR_B_WIDTH =
    $clog2(DEPTH_IN * (WIDTH_IN / WIDTH_OUT))
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  output logic                    full,
  output logic                    ram_we,
  output logic [ADDR_A_WIDTH-1:0] ram_addr_a,
  output logic [ADDR_B_WIDTH-1:0] ram_addr_b,
  input  logic [WIDTH_OUT-1:0]    ram_out,
  output logic [WIDTH_OUT-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_A_WIDTH:0]   word_count
`ifdef ASYM_FIFO_OVERFLOW_FLAG_EN
  ,
  output logic                    overflow
`endif
);

  localparam int RATIO  = WIDTH_IN / WIDTH_OUT;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [ADDR_A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_B_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_A_WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH_OUT-1:0]    data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    load;
  logic                    retire;
  logic                    last_lane;

  generate
    if (RATIO == 1) begin : g_r1
      assign last_lane = 1'b1;
    end else begin : g_rn
      assign last_lane = &rd_ptr_q[LANE_W-1:0];
    end
  endgenerate

  assign full   = (cnt_q == (ADDR_A_WIDTH+1)'(DEPTH_IN));
  assign ram_we = push & ~full;
  assign load   = (cnt_q != '0)
                & (~valid_q | out_ready);
  assign retire = load & last_lane;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    if (ram_we)
      wr_ptr_d = wr_ptr_q + ADDR_A_WIDTH'(1);
    if (load) begin
      rd_ptr_d = rd_ptr_q + ADDR_B_WIDTH'(1);
      data_d   = ram_out;
      valid_d  = 1'b1;
    end else if (out_ready) begin
      valid_d  = 1'b0;
    end
    unique case (1'b1)
      (ram_we & ~retire):
        cnt_d = cnt_q + (ADDR_A_WIDTH+1)'(1);
      (retire & ~ram_we):
        cnt_d = cnt_q - (ADDR_A_WIDTH+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

`ifdef ASYM_FIFO_OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q | (push & full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

  assign ram_addr_a = wr_ptr_q;
  assign ram_addr_b = rd_ptr_q;
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign word_count = cnt_q;

endmodule
